// File: rtl/map_tile_writer.sv
// 13x13 destructible map tile store: combinational read port plus a valid/ready
// read-modify-write damage port. Optional macro MAP_WALL_DAMAGE_EN makes WALL tiles destructible.
module map_tile_writer #(
    parameter int unsigned MAP_SIZE   = 13,
    parameter logic [3:0]  INIT_STATE = 4'hF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       map_enable_i,
    input  logic [3:0] map_x_i,
    input  logic [3:0] map_y_i,
    output logic [2:0] block_type_o,
    output logic [3:0] block_state_o,
    input  logic       dmg_valid_i,
    output logic       dmg_ready_o,
    input  logic [3:0] dmg_x_i,
    input  logic [3:0] dmg_y_i,
    input  logic [3:0] dmg_amount_i,
    output logic       dmg_done_o,
    output logic [1:0] dmg_result_o,
    input  logic       restart_i,
    output logic       busy_o
);

    localparam int unsigned      NUM_TILES = MAP_SIZE * MAP_SIZE;
    localparam int unsigned      IDX_W     = $clog2(NUM_TILES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TILES - 1);
    localparam logic [3:0]       LAST_COL  = 4'(MAP_SIZE - 1);
    localparam logic [4:0]       SIZE5     = 5'(MAP_SIZE);

    localparam logic [2:0] BRICK = 3'b000;
    localparam logic [2:0] WALL  = 3'b001;
    localparam logic [2:0] AIR   = 3'b111;

    localparam logic [1:0] RES_NONE      = 2'b00;
    localparam logic [1:0] RES_DAMAGED   = 2'b01;
    localparam logic [1:0] RES_DESTROYED = 2'b10;
    localparam logic [1:0] RES_RANGE     = 2'b11;

    typedef enum logic [2:0] {IDLE, CHECK, WRITE, RESP, LOAD} state_e;

    // Level-start layout; used by the async reset and by the restart sweep.
    function automatic logic [6:0] defaultTile(input int unsigned row, input int unsigned col);
        logic [2:0] t;
        t = AIR;
        if (((row >= 1 && row <= 4) || (row >= 8 && row <= 11)) && (col % 2 == 1)) t = BRICK;
        if (row == 3 && col == 6) t = WALL;
        if (row == 10 && col == 6) t = BRICK;
        if (row == 6) begin
            if (col == 0 || col == 12) t = WALL;
            if (col == 2 || col == 3 || col == 9 || col == 10) t = BRICK;
        end
        return {t, INIT_STATE};
    endfunction

    function automatic logic [IDX_W-1:0] tileIdx(input logic [3:0] row, input logic [3:0] col);
        return IDX_W'(row) * IDX_W'(MAP_SIZE) + IDX_W'(col);
    endfunction

    state_e           state_q, state_d;
    logic [6:0]       tiles_q [NUM_TILES];
    logic [3:0]       reqX_q, reqY_q, reqAmt_q;
    logic [1:0]       result_q;
    logic [6:0]       newTile_q;
    logic [3:0]       loadRow_q, loadCol_q;
    logic [IDX_W-1:0] loadIdx_q;

    logic             rdInRange;
    logic [IDX_W-1:0] rdIdx;
    logic             reqInRange;
    logic [IDX_W-1:0] reqIdx;
    logic [6:0]       curTile;
    logic             canDamage;
    logic [1:0]       evalResult;
    logic [6:0]       evalTile;

    always_comb begin
        rdInRange     = ({1'b0, map_x_i} < SIZE5) && ({1'b0, map_y_i} < SIZE5);
        rdIdx         = tileIdx(map_y_i, map_x_i);
        block_type_o  = AIR;
        block_state_o = 4'b0;
        if (map_enable_i && rdInRange) begin
            {block_type_o, block_state_o} = tiles_q[rdIdx];
        end
    end

    always_comb begin
        reqInRange = ({1'b0, reqX_q} < SIZE5) && ({1'b0, reqY_q} < SIZE5);
        reqIdx     = tileIdx(reqY_q, reqX_q);
        curTile    = {AIR, 4'b0};
        if (reqInRange) begin
            curTile = tiles_q[reqIdx];
        end
`ifdef MAP_WALL_DAMAGE_EN
        canDamage = (curTile[6:4] == BRICK) || (curTile[6:4] == WALL);
`else
        canDamage = (curTile[6:4] == BRICK);
`endif
        evalResult = RES_NONE;
        evalTile   = curTile;
        if (!reqInRange) begin
            evalResult = RES_RANGE;
        end else if (canDamage && reqAmt_q != 4'b0) begin
            if (reqAmt_q >= curTile[3:0]) begin
                evalResult = RES_DESTROYED;
                evalTile   = {AIR, 4'b0};
            end else begin
                evalResult = RES_DAMAGED;
                evalTile   = {curTile[6:4], curTile[3:0] - reqAmt_q};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_TILES; i++) begin
                tiles_q[i] <= defaultTile(i / MAP_SIZE, i % MAP_SIZE);
            end
        end else if (state_q == LOAD) begin
            tiles_q[loadIdx_q] <= defaultTile(32'(loadRow_q), 32'(loadCol_q));
        end else if (state_q == WRITE &&
                     (result_q == RES_DAMAGED || result_q == RES_DESTROYED)) begin
            tiles_q[reqIdx] <= newTile_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reqX_q    <= 4'b0;
            reqY_q    <= 4'b0;
            reqAmt_q  <= 4'b0;
            result_q  <= RES_NONE;
            newTile_q <= 7'b0;
        end else begin
            if (state_q == IDLE && !restart_i && dmg_valid_i) begin
                reqX_q   <= dmg_x_i;
                reqY_q   <= dmg_y_i;
                reqAmt_q <= dmg_amount_i;
            end
            if (state_q == CHECK) begin
                result_q  <= evalResult;
                newTile_q <= evalTile;
            end
        end
    end

    // Sweep position is kept as row/col and as a linear index to avoid a divider.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            loadRow_q <= 4'b0;
            loadCol_q <= 4'b0;
            loadIdx_q <= '0;
        end else if (state_q == IDLE) begin
            loadRow_q <= 4'b0;
            loadCol_q <= 4'b0;
            loadIdx_q <= '0;
        end else if (state_q == LOAD) begin
            loadIdx_q <= loadIdx_q + 1'b1;
            if (loadCol_q == LAST_COL) begin
                loadCol_q <= 4'b0;
                loadRow_q <= loadRow_q + 4'd1;
            end else begin
                loadCol_q <= loadCol_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready drops while restart_i is high so a pending request is never seen as handed off.
    always_comb begin
        state_d      = state_q;
        dmg_ready_o  = 1'b0;
        busy_o       = 1'b1;
        dmg_done_o   = 1'b0;
        dmg_result_o = RES_NONE;
        case (state_q)
            IDLE: begin
                busy_o      = 1'b0;
                dmg_ready_o = !restart_i;
                if (restart_i) begin
                    state_d = LOAD;
                end else if (dmg_valid_i) begin
                    state_d = CHECK;
                end
            end
            CHECK: state_d = WRITE;
            WRITE: state_d = RESP;
            RESP: begin
                dmg_done_o   = 1'b1;
                dmg_result_o = result_q;
                state_d      = IDLE;
            end
            LOAD: begin
                if (loadIdx_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_map_tile_writer.sv
// Scoreboard bench for map_tile_writer: a tile-array reference model predicts
// damage results and read-port values; a monitor checks every done pulse.
module tb_map_tile_writer;

    localparam int N = 13;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       map_enable_i = 1'b0;
    logic [3:0] map_x_i = 4'd0;
    logic [3:0] map_y_i = 4'd0;
    logic [2:0] block_type_o;
    logic [3:0] block_state_o;
    logic       dmg_valid_i = 1'b0;
    logic       dmg_ready_o;
    logic [3:0] dmg_x_i = 4'd0;
    logic [3:0] dmg_y_i = 4'd0;
    logic [3:0] dmg_amount_i = 4'd0;
    logic       dmg_done_o;
    logic [1:0] dmg_result_o;
    logic       restart_i = 1'b0;
    logic       busy_o;

    map_tile_writer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .map_enable_i (map_enable_i),
        .map_x_i      (map_x_i),
        .map_y_i      (map_y_i),
        .block_type_o (block_type_o),
        .block_state_o(block_state_o),
        .dmg_valid_i  (dmg_valid_i),
        .dmg_ready_o  (dmg_ready_o),
        .dmg_x_i      (dmg_x_i),
        .dmg_y_i      (dmg_y_i),
        .dmg_amount_i (dmg_amount_i),
        .dmg_done_o   (dmg_done_o),
        .dmg_result_o (dmg_result_o),
        .restart_i    (restart_i),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]  res;
        int unsigned due;
    } exp_t;

    exp_t       expQ[$];
    logic [6:0] model [N][N];
    int         vectors = 0;
    int         miscompares = 0;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic loadDefaultModel();
        int brickCols[4] = '{2, 3, 9, 10};
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                model[r][c] = {3'b111, 4'hF};
        for (int r = 1; r <= 11; r++)
            if (r <= 4 || r >= 8)
                for (int c = 1; c < N; c += 2)
                    model[r][c] = {3'b000, 4'hF};
        model[3][6]  = {3'b001, 4'hF};
        model[10][6] = {3'b000, 4'hF};
        model[6][0]  = {3'b001, 4'hF};
        model[6][12] = {3'b001, 4'hF};
        foreach (brickCols[k]) model[6][brickCols[k]] = {3'b000, 4'hF};
    endtask

    task automatic refDamage(input int x, input int y, input int amt, output logic [1:0] res);
        logic [6:0] t;
        bit hurts;
        res = 2'b00;
        if (x >= N || y >= N) begin
            res = 2'b11;
            return;
        end
        t = model[y][x];
`ifdef MAP_WALL_DAMAGE_EN
        hurts = (t[6:4] == 3'b000) || (t[6:4] == 3'b001);
`else
        hurts = (t[6:4] == 3'b000);
`endif
        if (!hurts || amt == 0) return;
        if (amt >= int'(t[3:0])) begin
            model[y][x] = {3'b111, 4'h0};
            res = 2'b10;
        end else begin
            model[y][x] = {t[6:4], 4'(int'(t[3:0]) - amt)};
            res = 2'b01;
        end
    endtask

    task automatic checkOutput(input logic en, input int x, input int y);
        logic [6:0] exp;
        @(negedge clk);
        map_enable_i = en;
        map_x_i = 4'(x);
        map_y_i = 4'(y);
        #1;
        exp = (!en || x >= N || y >= N) ? {3'b111, 4'h0} : model[y][x];
        checkValue($sformatf("read(row %0d,col %0d,en %0d)", y, x, en),
                   {25'b0, block_type_o, block_state_o}, {25'b0, exp});
    endtask

    task automatic applyStimulus(input int x, input int y, input int amt, input bit holdValid);
        logic [1:0] res;
        bit rdy;
        bit accepted = 0;
        @(negedge clk);
        dmg_valid_i = 1'b1;
        dmg_x_i = 4'(x);
        dmg_y_i = 4'(y);
        dmg_amount_i = 4'(amt);
        for (int k = 0; k < 64 && !accepted; k++) begin
            #1 rdy = dmg_ready_o;
            @(posedge clk);
            if (rdy) begin
                accepted = 1;
                refDamage(x, y, amt, res);
                expQ.push_back('{res: res, due: cyc + 3});
            end else begin
                @(negedge clk);
            end
        end
        if (!accepted) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL acceptTimeout: got no ready, expected accept of (row %0d,col %0d)", y, x);
        end
        @(negedge clk);
        dmg_valid_i = holdValid;
        dmg_x_i = 4'($urandom_range(15));
        dmg_y_i = 4'($urandom_range(15));
        dmg_amount_i = 4'($urandom_range(15));
    endtask

    task automatic waitIdle();
        @(negedge clk);
        dmg_valid_i = 1'b0;
        for (int k = 0; k < 64 && expQ.size() != 0; k++) @(negedge clk);
        if (expQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL idleTimeout: got %0d pending, expected 0", expQ.size());
            expQ.delete();
        end
        @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkValue({tag, ".ready"},  {31'b0, dmg_ready_o}, 32'd1);
        checkValue({tag, ".busy"},   {31'b0, busy_o}, 32'd0);
        checkValue({tag, ".done"},   {31'b0, dmg_done_o}, 32'd0);
        checkValue({tag, ".result"}, {30'b0, dmg_result_o}, 32'd0);
    endtask

    // Scoreboard monitor: pops one expectation per done pulse and checks its timing.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (expQ.size() != 0)
                checkValue("readyInFlight", {31'b0, dmg_ready_o}, 32'd0);
            if (dmg_done_o) begin
                if (expQ.size() == 0) begin
                    checkValue("unexpectedDone", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkValue("dmgResult", {30'b0, dmg_result_o}, {30'b0, e.res});
                    checkValue("doneCycle", cyc, e.due);
                end
            end else if (expQ.size() != 0 && cyc >= expQ[0].due) begin
                checkValue("missingDone", 32'd0, 32'd1);
                void'(expQ.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        loadDefaultModel();
        #1;
        checkResetOutputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        checkOutput(1, 1, 1);
        checkOutput(1, 0, 6);
        checkOutput(0, 1, 1);
        checkOutput(1, 2, 13);
        checkOutput(1, 6, 3);
        checkOutput(1, 6, 10);
        checkOutput(1, 12, 6);

        applyStimulus(1, 1, 5, 0);
        waitIdle();
        checkOutput(1, 1, 1);
        applyStimulus(1, 1, 12, 0);
        waitIdle();
        checkOutput(1, 1, 1);

        applyStimulus(0, 0, 3, 0);
        applyStimulus(0, 6, 8, 0);
        applyStimulus(0, 6, 8, 0);
        applyStimulus(14, 2, 4, 0);
        applyStimulus(3, 1, 0, 0);
        waitIdle();
        checkOutput(1, 0, 6);
        checkOutput(1, 3, 1);

        applyStimulus(5, 1, 2, 1);
        applyStimulus(5, 2, 3, 1);
        applyStimulus(7, 9, 15, 0);
        waitIdle();
        checkOutput(1, 5, 1);
        checkOutput(1, 7, 9);

        for (int i = 0; i < 60; i++) begin
            int x, y;
            if ($urandom_range(1) == 1) begin
                x = 2 * $urandom_range(5) + 1;
                y = $urandom_range(4, 1);
            end else begin
                x = $urandom_range(14);
                y = $urandom_range(14);
            end
            applyStimulus(x, y, $urandom_range(15), 1'($urandom_range(1)));
            if ($urandom_range(3) == 0) begin
                waitIdle();
                checkOutput(1, $urandom_range(14), $urandom_range(14));
            end
        end
        waitIdle();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                checkOutput(1, c, r);

        applyStimulus(3, 2, 15, 0);
        waitIdle();
        checkOutput(1, 3, 2);
        @(negedge clk);
        restart_i = 1'b1;
        dmg_valid_i = 1'b1;
        dmg_x_i = 4'd1;
        dmg_y_i = 4'd2;
        dmg_amount_i = 4'd1;
        @(posedge clk);
        @(negedge clk);
        restart_i = 1'b0;
        dmg_valid_i = 1'b0;
        n = 0;
        while (busy_o && n < 400) begin
            n++;
            if (n == 50) restart_i = 1'b1;
            if (n == 51) restart_i = 1'b0;
            @(negedge clk);
        end
        checkValue("loadCycles", n, 32'd169);
        loadDefaultModel();
        checkOutput(1, 3, 2);
        checkOutput(1, 1, 1);

        applyStimulus(1, 8, 3, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs("resetInWrite");
        expQ.delete();
        loadDefaultModel();
        checkOutput(1, 1, 8);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput(1, 1, 8);

        applyStimulus(11, 11, 4, 0);
        waitIdle();
        checkOutput(1, 11, 11);
        @(negedge clk);
        restart_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        restart_i = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs("resetInLoad");
        loadDefaultModel();
        checkOutput(1, 11, 11);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkValue("idleAfterReset", {31'b0, busy_o}, 32'd0);
        checkOutput(1, 11, 11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
